// File: rtl/audio_fifo_write_ctrl.sv
// audio2fifo write sequencer: source handshake -> registered FIFO write, watermark hysteresis,
// pause/stop/drain. Optional drain timeout enabled by defining AUDIO_FIFO_CTRL_DRAIN_TIMEOUT_EN.
module audio_fifo_write_ctrl #(
  parameter int          DATA_W        = 32,
  parameter int          USED_W        = 12,
  parameter int          HIGH_WATER    = 3584,
  parameter int          LOW_WATER     = 1024,
  parameter int unsigned DRAIN_TIMEOUT = 65536
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cfg_start,
  input  logic              cfg_pause,
  input  logic              cfg_stop,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [USED_W-1:0] fifo_used,
  output logic              fifo_wrreq,
  output logic [DATA_W-1:0] fifo_data,
  output logic              out_pause,
  output logic              out_stop,
  output logic              refill_irq,
  output logic [2:0]        state_o,
  output logic [31:0]       words_written,
  output logic [15:0]       underrun_cnt,
  output logic              drain_timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    HOLD  = 3'd2,
    PAUSE = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Watermarks must satisfy LOW < HIGH <= 2^USED_W-1; HIGH >= 2 keeps the ready margin non-negative.
  if (!(LOW_WATER < HIGH_WATER && HIGH_WATER >= 2 && HIGH_WATER <= (1 << USED_W) - 1 &&
        DRAIN_TIMEOUT >= 1)) begin : g_bad_param
    $error("audio_fifo_write_ctrl: illegal watermark/timeout parameters");
  end

  localparam logic [USED_W-1:0] HI_LVL  = USED_W'(HIGH_WATER);
  localparam logic [USED_W-1:0] LO_LVL  = USED_W'(LOW_WATER);
  localparam logic [USED_W-1:0] RDY_LVL = USED_W'(HIGH_WATER - 2);

  state_t state, state_nxt;
  logic   xfer, start_ok, refill_nxt, to_hit;
  logic   armed, empty_q, underrun_evt;

  // Ready stays low during reset so the source never hands over a sample the reset would discard.
  assign src_ready = reset_reset_n && (state == FILL) && !fifo_full &&
                     (fifo_used < RDY_LVL) && !cfg_pause && !cfg_stop;
  assign xfer      = src_valid && src_ready;
  assign start_ok  = (state == IDLE) && cfg_start && !cfg_stop;

  assign underrun_evt = armed && fifo_empty && !empty_q && ((state == FILL) || (state == HOLD));

  always_comb begin
    state_nxt  = state;
    refill_nxt = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = FILL;
      FILL: begin
        if (cfg_stop)                 state_nxt = DRAIN;
        else if (cfg_pause)           state_nxt = PAUSE;
        else if (fifo_used >= HI_LVL) state_nxt = HOLD;
      end
      HOLD: begin
        if (cfg_stop)                state_nxt = DRAIN;
        else if (cfg_pause)          state_nxt = PAUSE;
        else if (fifo_used < LO_LVL) begin
          state_nxt  = FILL;
          refill_nxt = 1'b1;
        end
      end
      PAUSE: begin
        if (cfg_stop)        state_nxt = DRAIN;
        else if (!cfg_pause) state_nxt = FILL;
      end
      DRAIN: if (fifo_empty || to_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AUDIO_FIFO_CTRL_DRAIN_TIMEOUT_EN
  logic [31:0] drain_cnt;
  logic        drain_to_q;

  assign to_hit        = (state == DRAIN) && !fifo_empty && (drain_cnt == 32'(DRAIN_TIMEOUT - 1));
  assign drain_timeout = drain_to_q;

  // Held at zero outside DRAIN, so every DRAIN entry starts a fresh count.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      drain_cnt  <= '0;
      drain_to_q <= 1'b0;
    end else begin
      if (state != DRAIN)   drain_cnt <= '0;
      else if (!fifo_empty) drain_cnt <= drain_cnt + 32'd1;
      if (start_ok)         drain_to_q <= 1'b0;
      else if (to_hit)      drain_to_q <= 1'b1;
    end
  end
`else
  assign to_hit        = 1'b0;
  assign drain_timeout = 1'b0;
`endif

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state         <= IDLE;
      fifo_wrreq    <= 1'b0;
      fifo_data     <= '0;
      refill_irq    <= 1'b0;
      words_written <= '0;
      underrun_cnt  <= '0;
      armed         <= 1'b0;
      empty_q       <= 1'b1;
    end else begin
      state      <= state_nxt;
      fifo_wrreq <= xfer;
      refill_irq <= refill_nxt;
      empty_q    <= fifo_empty;
      if (xfer) fifo_data <= src_data;
      if (start_ok) begin
        words_written <= '0;
        underrun_cnt  <= '0;
        armed         <= 1'b0;
      end else begin
        if (xfer) begin
          words_written <= words_written + 32'd1;
          armed         <= 1'b1;
        end
        if (underrun_evt && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

  assign out_pause = (state == PAUSE);
  assign out_stop  = (state == IDLE);
  assign state_o   = state;

endmodule
